uart_rx_os: RTL
===============

// Module: uart_rx_os
// PURPOSE
//  Parametrised UART receiver, next generation of the 8-bit/parity-bit Rx.
//  Adds a 2-FF input synchroniser, configurable frame format, 3-sample majority vote,
//  parity check, framing/break/overrun detection and a valid/ready output handshake.
//  Sits between the board RX pin and the consumer logic (register file, FIFO, display).
// PARAMETERS
//  CLK_HZ      50_000_000  system clock frequency
//  BAUD        9600        line bit rate
//  OVERSAMPLE  16          ticks per bit; even, >=8
//  DATA_BITS   8           payload bits, 5..9, LSB first
//  PARITY      0           0 none, 1 even, 2 odd
//  STOP_BITS   1           1 or 2
//  Derived: TICK_DIV = round(CLK_HZ/(BAUD*OVERSAMPLE)), >=2; MID = OVERSAMPLE/2.
// PORTS
//  clk         in   1          system clock, rising edge
//  n_rst       in   1          asynchronous, active-low reset
//  rx          in   1          asynchronous serial line, idle high
//  rx_ready    in   1          consumer accepts the word when rx_valid && rx_ready
//  rx_data     out  DATA_BITS  received payload; rx_data[0] = first bit on line
//  rx_valid    out  1          rx_data and error flags hold an unconsumed frame
//  parity_err  out  1          parity mismatch for the held frame (0 when PARITY=0)
//  frame_err   out  1          any stop bit voted 0 for the held frame
//  break_det   out  1          held frame: all data bits, parity and stop bits are 0
//  overrun     out  1          1-cycle pulse: completed frame dropped, previous frame unconsumed
//  busy        out  1          FSM not in IDLE
// BEHAVIOUR
//  Reset: all outputs 0; synchroniser FFs preset to 1; FSM=IDLE; counters 0.
//  rx passes through 2 FFs (rx_s). All decisions use rx_s only.
//  Tick divider: counts 0..TICK_DIV-1 and emits a 1-clk tick at wrap. Cleared on start detect.
//  Vote: samples rx_s at ticks MID-1, MID and MID+1 of each bit period.
//    Bit value = majority of the 3 samples, decided at tick MID+1.
//  FSM:
//   IDLE: rx_s 1->0 edge -> START; clear divider and tick count.
//   START: vote=1 -> IDLE (glitch, nothing reported). Vote=0 -> DATA.
//   DATA: after DATA_BITS votes, spaced OVERSAMPLE ticks apart, -> PARITY if PARITY!=0, else STOP.
//   PARITY: vote the parity bit.
//     even: error if XOR(data,p)=1. odd: error if XOR(data,p)=0.
//   STOP: vote STOP_BITS bits; any 0 sets frame_err.
//     At the last stop vote, complete the frame and go -> IDLE at mid-bit,
//     so resync is possible for the next start edge.
//  Completion: output regs load 1 clk after the last stop vote; rx_valid=1 from that cycle.
//   Latency from start-edge detect = (1+DATA_BITS+(PARITY?1:0)+STOP_BITS-1)*OVERSAMPLE+MID+1 ticks, +1 clk.
//  Handshake: rx_valid holds, and data and flags stay stable, until a cycle with rx_ready=1.
//   rx_valid falls on the next edge unless a new frame loads in that same cycle.
//  Completion while rx_valid=1 and not accepted that cycle: new frame discarded,
//   old data/flags kept, overrun pulses 1 clk.
//  Completion in the same cycle as acceptance: new frame loads, rx_valid stays 1, no overrun.
//  break_det implies frame_err=1. An erroneous frame is still delivered with rx_valid.
//  n_rst mid-frame: immediate return to reset values; the partial frame is lost.
//   The first full frame after release is received normally.
//  Width rules: bit counter sized clog2(DATA_BITS+1); tick counter clog2(OVERSAMPLE); divider clog2(TICK_DIV).
// TESTING
//  Sim params: CLK_HZ=1_600_000, BAUD=10_000, OVERSAMPLE=16 (TICK_DIV=10).
//  1) 8N1, send 0xA5, rx_ready=1 -> rx_valid 1 clk, rx_data=0xA5, all error flags 0.
//  2) 8E1, send 0x03 with parity bit 1 -> rx_data=0x03, parity_err=1, frame_err=0.
//     With parity bit 0 -> parity_err=0.
//  3) rx low for 40 clks (4 ticks), then high -> no rx_valid, busy returns 0 within one bit time.
//  4) 8N1, send 0x3C with stop=0 -> frame_err=1, break_det=0.
//     Send all zeros incl. stop -> break_det=1, frame_err=1.
//  5) rx_ready=0, send 0x11 then 0x22 -> rx_data=0x11 held, overrun pulses once.
//     Then pulse rx_ready -> rx_valid=0.
//  6) Assert n_rst=0 during bit 4 of 0x55 -> all outputs 0.
//     Release, send 0x96 -> rx_data=0x96, no errors.
//     Also: 7E2, 9-bit odd parity, 1-clk-jittered edges across +-2% baud.

Source files
------------

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: 2-FF synchroniser, 3-sample majority vote, configurable
// frame format, parity/framing/break/overrun flags and a valid/ready output handshake.
`timescale 1ns / 1ps
module uart_rx_os #(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 rx,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 break_det,
  output logic                 overrun,
  output logic                 busy
);
  localparam int unsigned TICK_DIV = (CLK_HZ + (BAUD * OVERSAMPLE) / 2) / (BAUD * OVERSAMPLE);
  localparam int unsigned MID      = OVERSAMPLE / 2;
  localparam int unsigned DIV_W    = $clog2(TICK_DIV);
  localparam int unsigned TCK_W    = $clog2(OVERSAMPLE);
  localparam int unsigned BIT_W    = $clog2(DATA_BITS + 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e               state;
  logic                 rx_meta, rx_s, rx_prev;
  logic [DIV_W-1:0]     div_cnt;
  logic [TCK_W-1:0]     tick_cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic [1:0]           samp;
  logic [DATA_BITS-1:0] shift;
  logic                 perr_acc, ferr_acc, seen_one, done;
  logic                 tick, smp_a, smp_b, vote_now, vote;

  // tick_cnt holds the number of ticks already elapsed in the bit, so the three samples
  // fall on the (MID-1)th, MIDth and (MID+1)th tick of the bit period.
  assign tick     = (div_cnt == DIV_W'(TICK_DIV - 1));
  assign smp_a    = tick && (tick_cnt == TCK_W'(MID - 2));
  assign smp_b    = tick && (tick_cnt == TCK_W'(MID - 1));
  assign vote_now = tick && (tick_cnt == TCK_W'(MID));
  assign vote     = (samp[0] & samp[1]) | (samp[0] & rx_s) | (samp[1] & rx_s);
  assign busy     = (state != StIdle);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= StIdle;
      div_cnt    <= '0;
      tick_cnt   <= '0;
      bit_cnt    <= '0;
      samp       <= '0;
      shift      <= '0;
      perr_acc   <= 1'b0;
      ferr_acc   <= 1'b0;
      seen_one   <= 1'b0;
      done       <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      break_det  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      done    <= 1'b0;
      overrun <= 1'b0;
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      if (tick) tick_cnt <= (tick_cnt == TCK_W'(OVERSAMPLE - 1)) ? '0 : tick_cnt + 1'b1;
      if (smp_a) samp[0] <= rx_s;
      if (smp_b) samp[1] <= rx_s;

      unique case (state)
        StIdle: begin
          if (rx_prev && !rx_s) begin
            state    <= StStart;
            div_cnt  <= '0;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            perr_acc <= 1'b0;
            ferr_acc <= 1'b0;
            seen_one <= 1'b0;
          end
        end
        StStart: if (vote_now) state <= vote ? StIdle : StData;
        StData: begin
          if (vote_now) begin
            shift    <= {vote, shift[DATA_BITS-1:1]};
            seen_one <= seen_one | vote;
            if (bit_cnt == BIT_W'(DATA_BITS - 1)) begin
              bit_cnt <= '0;
              state   <= (PARITY != 0) ? StParity : StStop;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        StParity: begin
          if (vote_now) begin
            perr_acc <= (^shift ^ vote) ^ (PARITY == 2);
            seen_one <= seen_one | vote;
            state    <= StStop;
          end
        end
        StStop: begin
          if (vote_now) begin
            ferr_acc <= ferr_acc | ~vote;
            seen_one <= seen_one | vote;
            if (bit_cnt == BIT_W'(STOP_BITS - 1)) begin
              // Leave at mid-stop so the next start edge can be caught early.
              bit_cnt <= '0;
              state   <= StIdle;
              done    <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        default: state <= StIdle;
      endcase

      if (done) begin
        if (rx_valid && !rx_ready) begin
          overrun <= 1'b1;
        end else begin
          rx_data    <= shift;
          parity_err <= perr_acc;
          frame_err  <= ferr_acc;
          break_det  <= ~seen_one;
          rx_valid   <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule
